countdown_timer: RTL and testbench
==================================

# countdown_timer

Loadable down-counter timer, the counting-down counterpart of the free-running up-counter. It counts a programmed value down to zero and flags terminal count. It runs in one-shot or periodic (auto-reload) mode, so testbenches and control logic can schedule timeouts and periodic ticks from a single clock.

## Interface
Parameters:
- WIDTH, 8, width of count and load value
- PRESCALE_W, 4, prescaler width; only used when COUNTDOWN_PRESCALE_EN is defined

Ports:
- clk  input  1  single clock; all state updates on posedge clk
- reset  input  1  asynchronous, active-high reset
- load  input  1  write load_value into reload register and counter
- load_value  input  WIDTH  value written on load
- start  input  1  begin or resume counting
- stop  input  1  pause counting; count holds
- periodic  input  1  1 = auto-reload at terminal count, 0 = one-shot; sampled every cycle
- prescale  input  PRESCALE_W  tick divider; port exists only with COUNTDOWN_PRESCALE_EN
- out  output  WIDTH  current count, registered
- busy  output  1  high while in RUN
- tc  output  1  one-cycle terminal-count pulse, registered

## Operation
- States: IDLE, RUN. busy = (state == RUN).
- Reset, asynchronous: state IDLE, out = 0, reload register = 0, tc = 0, busy = 0, prescaler = 0.
- Per-edge priority: stop > load > start > count.
- stop: RUN -> IDLE. out holds and tc = 0. If stop and start are high together, stop wins.
- load, in any state: reload <= load_value and out <= load_value. State is unchanged unless one of these applies:
  - load_value == 0 in RUN -> IDLE with no tc.
  - start is also high in IDLE -> RUN if load_value != 0.
- start in IDLE: out != 0 -> RUN. out == 0 -> stay IDLE with no tc. Resume after stop continues from the held count. start in RUN is ignored.
- Count step, in RUN with a tick and no stop or load:
  - out > 1: out <= out - 1.
  - out == 1, one-shot: out <= 0, tc <= 1, state -> IDLE.
  - out == 1, periodic: out <= reload, tc <= 1, stay RUN. If reload == 0, out <= 0 and state -> IDLE, still with tc.
- tc is 0 on every edge other than a terminal-count edge.
- Arithmetic is unsigned modulo 2^WIDTH. out never wraps below 0.

## Timing
- Without prescaler, a tick occurs every clk.
- start sampled at edge k: busy = 1 after edge k. First decrement at edge k+1.
- One-shot, value V: tc high and out = 0 after edge k+V. busy falls on the same edge. busy stays high for V cycles.
- Periodic, reload V: tc pulses every V cycles. out cycles V, V-1, ..., 1, V.
- load in RUN at edge j: out = load_value after edge j. Next decrement at edge j+1.
- reset mid-count forces outputs to reset values immediately, without waiting for a clock edge.

## Configuration
- COUNTDOWN_PRESCALE_EN defined:
  - Adds the prescale port and an internal prescaler counter.
  - A tick occurs once every prescale+1 clk cycles while in RUN.
  - The prescaler clears on start, load, stop and reset.
  - prescale = 0 behaves identically to the macro being undefined.
- COUNTDOWN_PRESCALE_EN undefined: no prescale port, no prescaler logic, and a tick occurs every cycle.

## Test plan
- Reset at time 0, then load_value=5 with load, then start; periodic=0 -> out 5,4,3,2,1,0 over 5 cycles. tc pulses once when out becomes 0. busy is high for exactly 5 cycles, then IDLE.
- periodic=1, load 3, start -> out sequence 3,2,1,3,2,1,... tc pulses every 3 cycles. busy never drops.
- load 10, start, stop after 4 cycles -> out holds 6 and busy=0. A later start resumes: 5,4,... tc fires 6 cycles after resume.
- start and stop together in IDLE -> stays IDLE. load 0 then start -> stays IDLE with no tc.
- Assert reset mid-count (out=7, between clock edges) -> out=0, busy=0 and tc=0 immediately. After reset release with no start, out stays 0.
- With COUNTDOWN_PRESCALE_EN, prescale=2, load 2, start -> each decrement takes 3 cycles. tc fires 6 cycles after start.

Source files
------------

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot/periodic modes and a registered terminal-count pulse.
// Optional tick prescaler is enabled by defining COUNTDOWN_PRESCALE_EN.
module countdown_timer #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  periodic,
`ifdef COUNTDOWN_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale,
`endif
    output logic [WIDTH-1:0]      out,
    output logic                  busy,
    output logic                  tc
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_out, w_out_nxt;
    logic [WIDTH-1:0] r_reload, w_reload_nxt;
    logic             r_tc, w_tc_nxt;
    logic             w_tick;

`ifdef COUNTDOWN_PRESCALE_EN
    logic [PRESCALE_W-1:0] r_pre, w_pre_nxt;

    assign w_tick = (r_pre == prescale);

    // Prescaler restarts a full period whenever counting is (re)started, reloaded or paused.
    always_comb begin
        w_pre_nxt = r_pre;
        if (stop || load || start || r_state == IDLE) begin
            w_pre_nxt = '0;
        end else if (w_tick) begin
            w_pre_nxt = '0;
        end else begin
            w_pre_nxt = r_pre + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre <= '0;
        end else begin
            r_pre <= w_pre_nxt;
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_out_nxt    = r_out;
        w_reload_nxt = r_reload;
        w_tc_nxt     = 1'b0;
        if (stop) begin
            w_state_nxt = IDLE;
        end else if (load) begin
            w_reload_nxt = load_value;
            w_out_nxt    = load_value;
            if (load_value == '0) begin
                w_state_nxt = IDLE;
            end else if (start && r_state == IDLE) begin
                w_state_nxt = RUN;
            end
        end else if (start) begin
            if (r_state == IDLE && r_out != '0) begin
                w_state_nxt = RUN;
            end
        end else if (r_state == RUN && w_tick) begin
            if (r_out > WIDTH'(1)) begin
                w_out_nxt = r_out - WIDTH'(1);
            end else if (r_out == WIDTH'(1)) begin
                w_tc_nxt = 1'b1;
                // A zero reload cannot sustain periodic mode, so it ends like a one-shot.
                if (periodic && r_reload != '0) begin
                    w_out_nxt = r_reload;
                end else begin
                    w_out_nxt   = '0;
                    w_state_nxt = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_out    <= '0;
            r_reload <= '0;
            r_tc     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_out    <= w_out_nxt;
            r_reload <= w_reload_nxt;
            r_tc     <= w_tc_nxt;
        end
    end

    assign out  = r_out;
    assign busy = (r_state == RUN);
    assign tc   = r_tc;

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized plus directed bench for countdown_timer against a cycle-level reference model.
module tb_countdown_timer;

    localparam int WIDTH      = 8;
    localparam int PRESCALE_W = 4;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  load = 1'b0;
    logic [WIDTH-1:0]      load_value = '0;
    logic                  start = 1'b0;
    logic                  stop = 1'b0;
    logic                  periodic = 1'b0;
    logic [PRESCALE_W-1:0] pscale = '0;
    logic [WIDTH-1:0]      out;
    logic                  busy;
    logic                  tc;

    int checks = 0;
    int failures = 0;

    // Reference model state: plain integers, not the DUT encoding.
    int m_cnt = 0;
    int m_rel = 0;
    bit m_run = 0;
    bit m_tc  = 0;
    int m_pre = 0;

    countdown_timer #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .stop       (stop),
        .periodic   (periodic),
`ifdef COUNTDOWN_PRESCALE_EN
        .prescale   (pscale),
`endif
        .out        (out),
        .busy       (busy),
        .tc         (tc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int period_len();
`ifdef COUNTDOWN_PRESCALE_EN
        return int'(pscale) + 1;
`else
        return 1;
`endif
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_rel = 0; m_run = 0; m_tc = 0; m_pre = 0;
    endtask

    // One clock edge of the timer rules, applied to the inputs seen at that edge.
    task automatic model_step();
        m_tc = 0;
        if (stop) begin
            m_run = 0;
            m_pre = 0;
        end else if (load) begin
            m_rel = int'(load_value);
            m_cnt = m_rel;
            if (m_rel == 0) m_run = 0;
            else if (start) m_run = 1;
            m_pre = 0;
        end else if (start) begin
            if (m_cnt != 0) m_run = 1;
            m_pre = 0;
        end else if (m_run) begin
            m_pre++;
            if (m_pre >= period_len()) begin
                m_pre = 0;
                if (m_cnt > 1) begin
                    m_cnt--;
                end else begin
                    m_tc = 1;
                    if (periodic && m_rel != 0) m_cnt = m_rel;
                    else begin m_cnt = 0; m_run = 0; end
                end
            end
        end
    endtask

    task automatic cyc(input bit ld, input int lv, input bit st, input bit sp);
        load = ld; load_value = WIDTH'(lv); start = st; stop = sp;
        @(posedge clk);
        model_step();
        #1;
        chk("out", 32'(out), 32'(m_cnt));
        chk("busy", 32'(busy), 32'(m_run));
        chk("tc", 32'(tc), 32'(m_tc));
        load = 0; start = 0; stop = 0;
    endtask

    initial begin
        int busy_n, tc_n, wait_n;
        #1;
        chk("rst_out", 32'(out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tc", 32'(tc), 0);
        #12 reset = 1'b0;
        model_reset();

        // One-shot of 5
        periodic = 0;
        cyc(1, 5, 0, 0);
        cyc(0, 0, 1, 0);
        chk("os_start_out", 32'(out), 5);
        busy_n = 1; tc_n = 0;
        for (int i = 0; i < 7; i++) begin
            cyc(0, 0, 0, 0);
            busy_n += int'(busy);
            tc_n += int'(tc);
        end
        chk("os_busy_cycles", busy_n, 5);
        chk("os_tc_count", tc_n, 1);
        chk("os_final_out", 32'(out), 0);

        // Periodic reload 3
        periodic = 1;
        cyc(1, 3, 1, 0);
        busy_n = 0; tc_n = 0;
        for (int i = 0; i < 9; i++) begin
            cyc(0, 0, 0, 0);
            busy_n += int'(busy);
            tc_n += int'(tc);
        end
        chk("per_busy", busy_n, 9);
        chk("per_tc_count", tc_n, 3);
        chk("per_out", 32'(out), 3);
        cyc(0, 0, 0, 1);
        periodic = 0;

        // Stop and resume
        cyc(1, 10, 0, 0);
        cyc(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        chk("stop_hold_out", 32'(out), 6);
        chk("stop_busy", 32'(busy), 0);
        cyc(0, 0, 0, 0);
        chk("stop_still_6", 32'(out), 6);
        cyc(0, 0, 1, 0);
        wait_n = 0;
        while (!tc && wait_n < 50) begin
            cyc(0, 0, 0, 0);
            wait_n++;
        end
        chk("resume_tc_delay", wait_n, 6);

        // Start+stop together, and load 0 then start
        cyc(1, 4, 0, 0);
        cyc(0, 0, 1, 1);
        chk("startstop_busy", 32'(busy), 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        chk("zero_start_busy", 32'(busy), 0);
        chk("zero_start_tc", 32'(tc), 0);

        // Asynchronous reset mid-count
        cyc(1, 10, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        chk("pre_rst_out", 32'(out), 7);
        #3 reset = 1'b1;
        #1;
        chk("arst_out", 32'(out), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_tc", 32'(tc), 0);
        model_reset();
        #2 reset = 1'b0;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        chk("post_rst_out", 32'(out), 0);

`ifdef COUNTDOWN_PRESCALE_EN
        pscale = 2;
        cyc(1, 2, 1, 0);
        wait_n = 0;
        while (!tc && wait_n < 50) begin
            cyc(0, 0, 0, 0);
            wait_n++;
        end
        chk("pre_tc_delay", wait_n, 6);
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) periodic = ~periodic;
`ifdef COUNTDOWN_PRESCALE_EN
            if ($urandom_range(0, 49) == 0) pscale = PRESCALE_W'($urandom_range(0, 3));
`endif
            cyc($urandom_range(0, 9) == 0, $urandom_range(0, 12),
                $urandom_range(0, 6) == 0, $urandom_range(0, 19) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
